logsin_operator: RTL and testbench

Sequencing stage that turns a phase increment and an attenuation into one signed linear sine sample per request, using log-domain arithmetic. It owns the phase accumulator. It drives the address of the quarter-wave log-sine ROM (synchronous, 1-cycle read) and consumes its `logsn` word. It then adds attenuation and drives an external exponent ROM (`sinpow[i] = round((2^(i/256)-1)*1024)`, synchronous, 1-cycle read), and shifts and signs the result for the downstream mixer.

---
 rtl/logsin_operator.sv | 142 ++++++++++++++
 tb/tb_logsin_operator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/logsin_operator.sv
// Log-domain sine sequencer: phase accumulator -> log-sine ROM -> +attenuation -> exponent ROM -> shift/sign.
// Define LOGSIN_ROUND_EN to round the final shift half-up instead of truncating.
module logsin_operator #(
  parameter int unsigned PHASE_W = 20,
  parameter int unsigned ATT_W   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [ATT_W-1:0]   atten,
  output logic [7:0]         log_addr,
  input  logic [15:0]        logsn,
  output logic [7:0]         pow_addr,
  input  logic [9:0]         sinpow,
  output logic               busy,
  output logic [11:0]        sample,
  output logic               out_valid,
  output logic               start_drop
);

  typedef enum logic [2:0] {
    IDLE,
    LOG_WAIT,
    LOG_SUM,
    POW_WAIT,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               sign_q, sign_d;
  logic [ATT_W-1:0]   att_q, att_d;
  logic [7:0]         log_addr_q, log_addr_d;
  logic [12:0]        total_q, total_d;
  logic [11:0]        sample_q, sample_d;
  logic               out_valid_q, out_valid_d;
  logic               start_drop_q, start_drop_d;

  logic [PHASE_W-1:0] acc_base;
  logic [9:0]         phase;
  logic [10:0]        mant;
  logic [4:0]         sh;
  logic [10:0]        mag;

  always_comb begin
    mant = {1'b1, sinpow};
    sh   = total_q[12:8];
    mag  = '0;
`ifdef LOGSIN_ROUND_EN
    if (sh == 5'd0) begin
      mag = mant;
    end else if (sh < 5'd11) begin
      // 12-bit sum keeps the carry from mant + half-LSB before shifting
      mag = 11'((12'(mant) + (12'd1 << (sh - 5'd1))) >> sh);
    end
`else
    if (sh < 5'd11) begin
      mag = mant >> sh;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    sign_d       = sign_q;
    att_d        = att_q;
    log_addr_d   = log_addr_q;
    total_d      = total_q;
    sample_d     = sample_q;
    out_valid_d  = 1'b0;
    start_drop_d = start_drop_q;

    acc_base = phase_clr ? '0 : acc_q;
    phase    = acc_base[PHASE_W-1 -: 10];

    if (phase_clr) begin
      acc_d = '0;
    end
    if (start && state_q != IDLE) begin
      start_drop_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = acc_base + phase_inc;
          sign_d     = phase[9];
          log_addr_d = phase[8] ? ~phase[7:0] : phase[7:0];
          att_d      = atten;
          state_d    = LOG_WAIT;
        end
      end
      LOG_WAIT: state_d = LOG_SUM;
      LOG_SUM: begin
        total_d = 13'(logsn[11:0]) + 13'(att_q);
        state_d = POW_WAIT;
      end
      POW_WAIT: state_d = SHIFT;
      SHIFT: begin
        sample_d    = sign_q ? 12'(-{1'b0, mag}) : {1'b0, mag};
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      sign_q       <= 1'b0;
      att_q        <= '0;
      log_addr_q   <= '0;
      total_q      <= '0;
      sample_q     <= '0;
      out_valid_q  <= 1'b0;
      start_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      sign_q       <= sign_d;
      att_q        <= att_d;
      log_addr_q   <= log_addr_d;
      total_q      <= total_d;
      sample_q     <= sample_d;
      out_valid_q  <= out_valid_d;
      start_drop_q <= start_drop_d;
    end
  end

  assign log_addr   = log_addr_q;
  assign pow_addr   = total_q[7:0];
  assign busy       = (state_q != IDLE);
  assign sample     = sample_q;
  assign out_valid  = out_valid_q;
  assign start_drop = start_drop_q;

endmodule

// File: tb/tb_logsin_operator.sv
// Directed bench for logsin_operator with formula-generated log-sine and exponent ROM models.
module tb_logsin_operator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        phase_clr = 1'b0;
  logic [19:0] phase_inc = '0;
  logic [11:0] atten = '0;
  logic [7:0]  log_addr;
  logic [15:0] logsn = '0;
  logic [7:0]  pow_addr;
  logic [9:0]  sinpow = '0;
  logic        busy;
  logic [11:0] sample;
  logic        out_valid;
  logic        start_drop;

  int total = 0;
  int bad   = 0;

  logic [11:0] log_rom [256];
  logic [9:0]  pow_rom [256];

  logsin_operator #(.PHASE_W(20), .ATT_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .phase_clr  (phase_clr),
    .phase_inc  (phase_inc),
    .atten      (atten),
    .log_addr   (log_addr),
    .logsn      (logsn),
    .pow_addr   (pow_addr),
    .sinpow     (sinpow),
    .busy       (busy),
    .sample     (sample),
    .out_valid  (out_valid),
    .start_drop (start_drop)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs; upper logsn nibble is junk the DUT must ignore
  always @(posedge clk) begin
    logsn  <= {4'hA, log_rom[log_addr]};
    sinpow <= pow_rom[pow_addr];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sample(input logic [19:0] inc, input logic [11:0] att, input logic clr,
                            input int exp_addr, input int exp_sample, input string tag);
    start     = 1'b1;
    phase_inc = inc;
    atten     = att;
    phase_clr = clr;
    tick();
    start     = 1'b0;
    phase_clr = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_laddr"}, int'(log_addr), exp_addr);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) chk({tag, "_early_valid"}, int'(out_valid), 0);
    end
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_busy_done"}, int'(busy), 0);
    chk({tag, "_sample"}, int'($signed(sample)), exp_sample);
  endtask

  initial begin
    int strobes;
    int first_c;
    int last_c;
    int gap_bad;

    for (int i = 0; i < 256; i++) begin
      real x;
      real v;
      x = (real'(i) + 0.5) / 256.0 * (3.14159265358979 / 2.0);
      v = -$ln($sin(x)) / $ln(2.0) * 256.0;
      log_rom[i] = 12'($rtoi(v + 0.5));
      v = ($pow(2.0, real'(i) / 256.0) - 1.0) * 1024.0;
      pow_rom[i] = 10'($rtoi(v + 0.5));
    end

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_laddr", int'(log_addr), 0);
    chk("rst_paddr", int'(pow_addr), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_drop", int'(start_drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_sample(20'h40000, 12'h000, 1'b1, 8'h00, 5, "ph000");
    chk("ph000_paddr", int'(pow_addr), 8'h59);
    run_sample(20'h00000, 12'h000, 1'b0, 8'hFF, 1024, "ph100");
    run_sample(20'h00000, 12'hB00, 1'b0, 8'hFF, 0, "ph100_sh11");
`ifdef LOGSIN_ROUND_EN
    run_sample(20'h00000, 12'h101, 1'b0, 8'hFF, 514, "ph100_t101");
`else
    run_sample(20'h00000, 12'h101, 1'b0, 8'hFF, 513, "ph100_t101");
`endif
    run_sample(20'h80000, 12'h180, 1'b0, 8'hFF, 724, "ph100_t180");
    run_sample(20'h00000, 12'h000, 1'b0, 8'hFF, -1024, "ph300");
    run_sample(20'h00000, 12'h100, 1'b0, 8'hFF, -512, "ph300_att256");
    run_sample(20'h00000, 12'hB00, 1'b0, 8'hFF, 0, "ph300_negzero");
    run_sample(20'h00000, 12'hFFF, 1'b1, 8'h00, 0, "ph000_attmax");
    chk("attmax_paddr", int'(pow_addr), 8'h58);
    chk("drop_before_b2b", int'(start_drop), 0);

    // start held high for 20 edges from IDLE
    strobes = 0;
    first_c = -1;
    last_c  = -1;
    gap_bad = 0;
    start     = 1'b1;
    phase_inc = 20'h10000;
    atten     = 12'h000;
    phase_clr = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      phase_clr = 1'b0;
      if (out_valid) begin
        if (last_c >= 0 && c - last_c != 5) gap_bad++;
        if (first_c < 0) first_c = c;
        last_c = c;
        strobes++;
      end
    end
    start = 1'b0;
    for (int c = 20; c < 26; c++) begin
      tick();
      if (out_valid) strobes++;
    end
    chk("b2b_strobes", strobes, 4);
    chk("b2b_first", first_c, 4);
    chk("b2b_gaps", gap_bad, 0);
    chk("b2b_drop", int'(start_drop), 1);
    run_sample(20'h00000, 12'h000, 1'b0, 8'hFF, 1024, "b2b_acc4x");

    // reset asserted while in POW_WAIT
    start     = 1'b1;
    phase_inc = 20'h40000;
    atten     = 12'h000;
    phase_clr = 1'b1;
    tick();
    start     = 1'b0;
    phase_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_laddr", int'(log_addr), 0);
    chk("mid_paddr", int'(pow_addr), 0);
    chk("mid_sample", int'(sample), 0);
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_drop", int'(start_drop), 0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) strobes++;
    end
    chk("mid_no_valid", strobes, 0);
    run_sample(20'h40000, 12'h000, 1'b0, 8'h00, 5, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
